neuron_accumulator: RTL and testbench
=====================================

Name: neuron_accumulator

Overview:
- Stage directly downstream of the 33-lane weight multiplier.
- Captures the multiplier's 33 real products: 32 weighted inputs plus the bias term at index 32.
- Sums them sequentially, LANES terms per cycle, into one real pre-activation value.
- Presents the value to the activation stage with a valid/ready handshake.

Parameters:
N_TERMS, 33, number of product terms summed (index N_TERMS-1 is the bias product)
LANES, 1, terms added per accumulation cycle; legal range 1..N_TERMS; the last group may be partial

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
acc_in  input  real[N_TERMS-1:0]  products from multiplier (mul_out)
acc_start  input  1  request to capture acc_in and begin a sum
acc_ready  output  1  accumulator can accept acc_start this cycle
acc_sum  output  real  accumulated result
acc_valid  output  1  acc_sum holds a completed result
acc_out_ready  input  1  downstream consumer accepts result
acc_busy  output  1  high while state is ACCUM

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (sampled high at a rising edge), from any state including mid-ACCUM:
  - state=IDLE; acc_sum=0.0; acc_valid=0; acc_busy=0; index=0; capture buffer cleared to 0.0.
  - acc_in is not captured during the reset cycle.
  - acc_start asserted together with reset is ignored.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - acc_ready=1.
  - acc_start=1 at an edge: copy all N_TERMS acc_in values into an internal buffer, clear the running sum to 0.0, index=0, go to ACCUM.
  - Later changes on acc_in do not affect the sum in progress.
- ACCUM:
  - acc_ready=0; acc_busy=1.
  - Each edge adds buffer[index .. min(index+LANES, N_TERMS)-1] to the running sum, then index += LANES.
  - Addition order is fixed for bit-exact checking: the group is summed left-to-right starting from the running sum, lowest index first.
  - When the group containing index N_TERMS-1 is added, go to DONE and set acc_sum to the final sum.
  - acc_start is ignored.
  - Accumulation takes ceil(N_TERMS/LANES) edges. Default: 33 edges after the start edge, acc_valid=1.
- DONE:
  - acc_valid=1; acc_sum stable.
  - acc_ready = acc_out_ready (combinational).
  - Edge with acc_out_ready=1 and acc_start=0: acc_valid→0, go to IDLE. acc_sum holds its last value.
  - Edge with acc_out_ready=1 and acc_start=1: the result is consumed and a new capture happens on the same edge; go straight to ACCUM with acc_valid→0 (back-to-back, no idle bubble).
  - acc_out_ready=0: hold indefinitely; acc_start is ignored.
- acc_sum changes only at the transition into DONE and on reset.
- Real arithmetic throughout: no saturation or rounding beyond IEEE double.
- A zero product contributes 0.0; the multiplier's enable masking is upstream.
- Illegal LANES (0 or >N_TERMS) is a fatal elaboration error.

Test Plan:
- Reset, then acc_in[i]=1.0 for all i, single acc_start pulse, acc_out_ready=1 → acc_ready drops next cycle; acc_valid rises exactly 33 edges after the start edge; acc_sum=33.0; one cycle later IDLE with acc_ready=1.
- acc_in[i]=i*0.5 (i=0..32), start, then acc_in changed to all -9.0 one cycle later → acc_sum=264.0, proving capture isolation.
- LANES=4, acc_in[i]=1.0, acc_in[32]=-2.0 → valid after 9 edges (last group 1 term); acc_sum=30.0.
- Result ready with acc_out_ready=0 for 10 cycles while acc_start pulses → acc_valid and acc_sum=33.0 held and starts ignored. Then acc_out_ready=1 with acc_start=1 and acc_in all 2.0 → ACCUM entered on that edge; next result 66.0 after 33 edges.
- reset asserted at edge 15 of ACCUM → next cycle IDLE, acc_sum=0.0, acc_valid=0, acc_busy=0. A fresh start then yields the correct full sum.
- acc_start and reset high on the same edge → remains IDLE, no accumulation.

Source files
------------

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: captures N_TERMS real products and sums them LANES at a
// time into one pre-activation value, handed off with a valid/ready handshake.
module neuron_accumulator #(
  parameter int unsigned N_TERMS = 33,
  parameter int unsigned LANES   = 1
) (
  input  logic clk,
  input  logic reset,
  input  real  acc_in [N_TERMS],
  input  logic acc_start,
  output logic acc_ready,
  output real  acc_sum,
  output logic acc_valid,
  input  logic acc_out_ready,
  output logic acc_busy
);

  localparam int unsigned IDX_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  // Reject lane counts that cannot form a valid grouping
  if (LANES < 1 || LANES > N_TERMS) begin : g_bad_lanes
    $fatal(1, "neuron_accumulator: LANES must be in 1..N_TERMS");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  real              buffer [N_TERMS];
  real              run_sum;
  real              grp_sum;
  logic [IDX_W-1:0] idx;
  logic             last_grp;
  logic             capture;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE can chain straight into a new capture
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc_start) state_nxt = ACCUM;
      ACCUM:   if (last_grp) state_nxt = DONE;
      DONE:    if (acc_out_ready) state_nxt = acc_start ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake decode: ready in IDLE, or in DONE when the consumer takes the result
  always_comb begin
    acc_ready = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        acc_ready = 1'b1;
        capture   = acc_start;
      end
      DONE: begin
        acc_ready = acc_out_ready;
        capture   = acc_out_ready & acc_start;
      end
      default: begin
        acc_ready = 1'b0;
        capture   = 1'b0;
      end
    endcase
  end

  // Group adder: running sum plus the current lane group, lowest index first
  always_comb begin
    grp_sum  = run_sum;
    last_grp = (32'(idx) + LANES) >= N_TERMS;
    for (int unsigned l = 0; l < LANES; l++) begin
      int unsigned k;
      k = 32'(idx) + l;
      if (k < N_TERMS) begin
        grp_sum = grp_sum + buffer[IDX_W'(k)];
      end
    end
  end

  // Datapath: capture buffer, running sum, lane index and registered status
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_TERMS; i++) begin
        buffer[i] <= 0.0;
      end
      run_sum   <= 0.0;
      idx       <= '0;
      acc_sum   <= 0.0;
      acc_valid <= 1'b0;
      acc_busy  <= 1'b0;
    end else begin
      acc_valid <= (state_nxt == DONE);
      acc_busy  <= (state_nxt == ACCUM);
      if (capture) begin
        buffer  <= acc_in;
        run_sum <= 0.0;
        idx     <= '0;
      end else if (state == ACCUM) begin
        run_sum <= grp_sum;
        idx     <= idx + IDX_W'(LANES);
        if (last_grp) begin
          acc_sum <= grp_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// tb_neuron_accumulator: table-driven and scoreboard checks of the real-valued
// sequential accumulator, with a LANES=4 instance for the partial-group case.
module tb_neuron_accumulator;

  localparam int unsigned N = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, out_ready_a, ready_a, valid_a, busy_a;
  logic start_b, out_ready_b, ready_b, valid_b, busy_b;
  real  in_a [N];
  real  in_b [N];
  real  sum_a, sum_b;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  real  sb_q [$];

  typedef struct {
    int kind;
    int exp_sum;
    int exp_lat;
  } vec_t;
  vec_t vecs [4];

  neuron_accumulator #(.N_TERMS(N), .LANES(1)) u_dut_a (
    .clk(clk), .reset(reset), .acc_in(in_a), .acc_start(start_a),
    .acc_ready(ready_a), .acc_sum(sum_a), .acc_valid(valid_a),
    .acc_out_ready(out_ready_a), .acc_busy(busy_a)
  );

  neuron_accumulator #(.N_TERMS(N), .LANES(4)) u_dut_b (
    .clk(clk), .reset(reset), .acc_in(in_b), .acc_start(start_b),
    .acc_ready(ready_b), .acc_sum(sum_b), .acc_valid(valid_b),
    .acc_out_ready(out_ready_b), .acc_busy(busy_b)
  );

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic chk_real(input string name, input real act, input real exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %f expected %f", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_a(input real v);
    for (int i = 0; i < N; i++) in_a[i] = v;
  endtask

  task automatic fill_kind(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       in_a[i] = 1.0;
        1:       in_a[i] = 0.5 * i;
        2:       in_a[i] = real'(i);
        default: in_a[i] = -1.0;
      endcase
    end
    if (kind == 3) in_a[N-1] = 10.0;
  endtask

  // Count edges after the start edge until valid; then pop and compare the sum
  task automatic wait_result(input string name, input int which, input int exp_lat);
    int  n;
    bit  seen;
    real exp_sum;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      tick();
      n++;
      if ((which == 0) ? valid_a : valid_b) seen = 1'b1;
    end
    if (!seen) begin
      total_cnt++;
      $display("FAIL %s_timeout: valid not seen after %0d edges, expected %0d", name, n, exp_lat);
    end else begin
      chk_int({name, "_latency"}, n, exp_lat);
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL %s_sb: result produced with empty scoreboard, got %f expected none",
                 name, (which == 0) ? sum_a : sum_b);
      end else begin
        exp_sum = sb_q.pop_front();
        chk_real({name, "_sum"}, (which == 0) ? sum_a : sum_b, exp_sum);
      end
    end
  endtask

  // One full transaction on instance A with the consumer always ready
  task automatic run_a(input string name, input int kind, input int exp_sum, input int exp_lat);
    out_ready_a = 1'b1;
    fill_kind(kind);
    start_a = 1'b1;
    sb_q.push_back(real'(exp_sum));
    tick();
    start_a = 1'b0;
    chk_bit({name, "_ready_drop"}, ready_a, 1'b0);
    chk_bit({name, "_busy"}, busy_a, 1'b1);
    if (kind == 1) fill_a(-9.0);
    wait_result(name, 0, exp_lat);
    chk_bit({name, "_ready_done"}, ready_a, 1'b1);
    tick();
    chk_bit({name, "_valid_clear"}, valid_a, 1'b0);
    chk_bit({name, "_ready_idle"}, ready_a, 1'b1);
    chk_real({name, "_sum_hold"}, sum_a, real'(exp_sum));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{kind: 0, exp_sum: 33,  exp_lat: 33};
    vecs[1] = '{kind: 1, exp_sum: 264, exp_lat: 33};
    vecs[2] = '{kind: 2, exp_sum: 528, exp_lat: 33};
    vecs[3] = '{kind: 3, exp_sum: -22, exp_lat: 33};

    reset       = 1'b1;
    start_a     = 1'b0;
    start_b     = 1'b0;
    out_ready_a = 1'b1;
    out_ready_b = 1'b1;
    fill_a(7.0);
    for (int i = 0; i < N; i++) in_b[i] = 0.0;
    tick();
    tick();
    reset = 1'b0;
    chk_bit("rst_valid", valid_a, 1'b0);
    chk_bit("rst_busy", busy_a, 1'b0);
    chk_bit("rst_ready", ready_a, 1'b1);
    chk_real("rst_sum", sum_a, 0.0);
    chk_bit("rst_b_valid", valid_b, 1'b0);

    // Table-driven patterns, including capture isolation (kind 1)
    for (int v = 0; v < 4; v++) begin
      run_a($sformatf("vec%0d", v), vecs[v].kind, vecs[v].exp_sum, vecs[v].exp_lat);
    end

    // Result held while consumer stalls; starts ignored; then back-to-back start
    out_ready_a = 1'b0;
    fill_a(1.0);
    start_a = 1'b1;
    sb_q.push_back(33.0);
    tick();
    start_a = 1'b0;
    wait_result("hold", 0, 33);
    for (int c = 0; c < 10; c++) begin
      start_a = (c % 2 == 0);
      fill_a(5.0);
      tick();
      chk_bit("hold_valid", valid_a, 1'b1);
      chk_real("hold_sum", sum_a, 33.0);
      chk_bit("hold_ready", ready_a, 1'b0);
    end
    fill_a(2.0);
    start_a     = 1'b1;
    out_ready_a = 1'b1;
    #1;
    chk_bit("b2b_ready_comb", ready_a, 1'b1);
    sb_q.push_back(66.0);
    tick();
    start_a = 1'b0;
    chk_bit("b2b_valid_drop", valid_a, 1'b0);
    chk_bit("b2b_busy", busy_a, 1'b1);
    fill_a(-4.0);
    wait_result("b2b", 0, 33);
    tick();
    chk_bit("b2b_idle", ready_a, 1'b1);

    // Reset on the 15th accumulation edge
    fill_a(3.0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (14) tick();
    chk_bit("midrst_busy_before", busy_a, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_bit("midrst_busy", busy_a, 1'b0);
    chk_bit("midrst_valid", valid_a, 1'b0);
    chk_bit("midrst_ready", ready_a, 1'b1);
    chk_real("midrst_sum", sum_a, 0.0);
    run_a("after_rst", 0, 33, 33);

    // Start coincident with reset is ignored
    fill_a(1.0);
    reset   = 1'b1;
    start_a = 1'b1;
    tick();
    reset   = 1'b0;
    start_a = 1'b0;
    chk_bit("rststart_busy", busy_a, 1'b0);
    chk_real("rststart_sum", sum_a, 0.0);
    repeat (40) tick();
    chk_bit("rststart_busy_later", busy_a, 1'b0);
    chk_bit("rststart_valid_later", valid_a, 1'b0);
    chk_bit("rststart_ready_later", ready_a, 1'b1);

    // LANES=4: partial final group holding only the bias product
    for (int i = 0; i < N; i++) in_b[i] = 1.0;
    in_b[N-1] = -2.0;
    start_b = 1'b1;
    sb_q.push_back(30.0);
    tick();
    start_b = 1'b0;
    chk_bit("l4_busy", busy_b, 1'b1);
    wait_result("l4", 1, 9);
    tick();
    chk_bit("l4_idle_ready", ready_b, 1'b1);
    chk_int("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
